// File: rtl/seg_pkg.sv
// seg_pkg -- shared types, constants and helpers for the serial 7-segment driver.
// Optional feature (see seg_serial_driver): SEG_AUTO_REFRESH_EN.

package seg_pkg;

   // Each cascaded digit register holds one byte of active-low segment bits.
   localparam int SEG_BITS_PER_DIGIT = 8;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } seg_state_e;

   // Number of bits needed to count 0..value-1. Never returns less than 1,
   // so a degenerate value of 1 still gets a usable one-bit counter.
   function automatic int seg_clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/seg_clk_div.sv
// seg_clk_div -- phase counter for the SEGCLK half-period.
// Counts CLK_DIV cycles while enabled and pulses tick on the last one, then
// starts over. Disabling it parks the count at zero, so every phase that the
// parent FSM enters begins with a full CLK_DIV cycles to run.

module seg_clk_div
   import seg_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CNT_W   = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   assign tick = en && (count_q == LAST_COUNT);

   // Advance the phase count; restart on terminal count or when idle.
   always_comb begin
      count_d = count_q;
      if (!en || tick) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // Phase counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/seg_serial_driver.sv
// seg_serial_driver -- shifts a DIGITS x 8-bit segment image out on the
// SEGCLK/SEGDT chain, blanking the display (SEGEN) while the chain moves.
// Optional feature: define SEG_AUTO_REFRESH_EN to re-send the held image
// every REFRESH cycles once the first external start has been seen.
//
// The pin-level outputs (SEGCLK, SEGDT, busy, done, SEGEN) are registered
// from the state of the previous cycle so the board sees clean, glitch-free
// edges. That registering adds one cycle between the accepted start and the
// done pulse: done arrives 16*DIGITS*CLK_DIV+1 cycles after acceptance.

module seg_serial_driver
   import seg_pkg::*;
#(
   parameter int DIGITS    = 8,
   parameter int CLK_DIV   = 4,
   parameter int MSB_FIRST = 1,
   parameter int REFRESH   = 1000000
) (
   input  logic                                 clk_100mhz,
   input  logic                                 RSTN,
   input  logic                                 start,
   input  logic [SEG_BITS_PER_DIGIT*DIGITS-1:0] data,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 SEGCLK,
   output logic                                 SEGDT,
   output logic                                 SEGEN,
   output logic                                 SEGCLR
);

   localparam int NBITS = SEG_BITS_PER_DIGIT * DIGITS;
   localparam int BW    = seg_clog2(NBITS);
   localparam int DW    = seg_clog2(CLK_DIV + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

   seg_state_e        state_q,     state_d;
   logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;
   logic [NBITS-1:0]  shadow_q,    shadow_d;
   logic              init_half_q, init_half_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              segclk_q,    segclk_d;
   logic              segdt_q,     segdt_d;
   logic              segen_q,     segen_d;
   logic              segclr_q,    segclr_d;

   logic              div_en;
   logic              div_tick;
   logic              idle_ok;
   logic              ext_go;
   logic              refresh_go;
   logic              accept;
   logic [BW-1:0]     bit_idx;
   logic              cur_bit;

   seg_clk_div #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (DW)
   ) u_clk_div (
      .clk   (clk_100mhz),
      .rst_n (RSTN),
      .en    (div_en),
      .tick  (div_tick)
   );

   // The cycle that shows done already has the FSM back in IDLE, so it is
   // excluded explicitly: a start coincident with done is dropped.
   assign idle_ok = (state_q == ST_IDLE) && !done_q;
   assign ext_go  = idle_ok && start;
   assign accept  = ext_go || refresh_go;

`ifdef SEG_AUTO_REFRESH_EN
   localparam int RW = seg_clog2(REFRESH);
   localparam logic [RW-1:0] LAST_REFRESH = RW'(REFRESH - 1);

   logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
   logic          armed_q,       armed_d;
   logic          pending_q,     pending_d;
   logic          refresh_tick;

   assign refresh_tick = (refresh_cnt_q == LAST_REFRESH);
   // An external start in the same cycle takes priority and supplies new data.
   assign refresh_go   = idle_ok && !start && armed_q && (refresh_tick || pending_q);

   // Free-running refresh timer; a tick that cannot be served is held pending.
   always_comb begin
      refresh_cnt_d = refresh_tick ? '0 : refresh_cnt_q + 1'b1;
      armed_d       = armed_q || ext_go;
      pending_d     = pending_q;
      if (accept) begin
         pending_d = 1'b0;
      end else if (refresh_tick && armed_q) begin
         pending_d = 1'b1;
      end
   end

   // Refresh timer and deferral registers.
   always_ff @(posedge clk_100mhz or negedge RSTN) begin
      if (!RSTN) begin
         refresh_cnt_q <= '0;
         armed_q       <= 1'b0;
         pending_q     <= 1'b0;
      end else begin
         refresh_cnt_q <= refresh_cnt_d;
         armed_q       <= armed_d;
         pending_q     <= pending_d;
      end
   end
`else
   assign refresh_go = 1'b0;
`endif

   // Select the image bit addressed by the bit counter in the chosen order.
   always_comb begin
      bit_idx = bit_cnt_q;
      if (MSB_FIRST != 0) begin
         bit_idx = LAST_BIT - bit_cnt_q;
      end
      cur_bit = shadow_q[bit_idx];
   end

   // Next-state and registered-output logic for the frame FSM.
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shadow_d    = shadow_q;
      init_half_d = init_half_q;
      busy_d      = busy_q;
      segen_d     = segen_q;
      segclr_d    = segclr_q;
      div_en      = 1'b0;

      case (state_q)
         ST_INIT: begin
            div_en = 1'b1;
            if (div_tick) begin
               if (init_half_q) begin
                  init_half_d = 1'b0;
                  segclr_d    = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  init_half_d = 1'b1;
               end
            end
         end
         ST_IDLE: begin
            if (accept) begin
               if (ext_go) begin
                  shadow_d = data;
               end
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               segen_d   = 1'b0;
               state_d   = ST_LOW;
            end
         end
         ST_LOW: begin
            div_en = 1'b1;
            if (div_tick) begin
               state_d = ST_HIGH;
            end
         end
         ST_HIGH: begin
            div_en = 1'b1;
            if (div_tick) begin
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = ST_DONE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  state_d   = ST_LOW;
               end
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            segen_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      done_d   = (state_q == ST_DONE);
      segclk_d = (state_q == ST_HIGH);
      segdt_d  = ((state_q == ST_LOW) || (state_q == ST_HIGH)) ? cur_bit : 1'b0;
   end

   // FSM, frame and output registers; everything drops at once on reset.
   always_ff @(posedge clk_100mhz or negedge RSTN) begin
      if (!RSTN) begin
         state_q     <= ST_INIT;
         bit_cnt_q   <= '0;
         shadow_q    <= '0;
         init_half_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         segclk_q    <= 1'b0;
         segdt_q     <= 1'b0;
         segen_q     <= 1'b0;
         segclr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shadow_q    <= shadow_d;
         init_half_q <= init_half_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         segclk_q    <= segclk_d;
         segdt_q     <= segdt_d;
         segen_q     <= segen_d;
         segclr_q    <= segclr_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign SEGCLK = segclk_q;
   assign SEGDT  = segdt_q;
   assign SEGEN  = segen_q;
   assign SEGCLR = segclr_q;

endmodule
